// File: rtl/ct_ifu_predecd_array_ctrl.sv
// ICache predecode array initiator: arbitrates invalidate sweep, refill writes and
// fetch reads onto the single-port array and returns read data one cycle later.
module ct_ifu_predecd_array_ctrl #(
  parameter int INDEX_W  = 16,
  parameter int ENTRY_AW = 10,
  parameter int DATA_W   = 32
) (
  input  logic               forever_cpuclk,
  input  logic               cpurst,
  input  logic               refill_wr_vld,
  output logic               refill_wr_rdy,
  input  logic [INDEX_W-1:0] refill_wr_index,
  input  logic [DATA_W-1:0]  refill_wr_data,
  input  logic               fetch_rd_vld,
  output logic               fetch_rd_rdy,
  input  logic [INDEX_W-1:0] fetch_rd_index,
  output logic               fetch_rd_data_vld,
  output logic [DATA_W-1:0]  fetch_rd_data,
  input  logic               inv_req,
  output logic               inv_busy,
  output logic               inv_done,
  output logic [INDEX_W-1:0] ifu_icache_index,
  output logic               ifu_icache_predecd_array0_cen_b,
  output logic               ifu_icache_predecd_array0_wen_b,
  output logic               ifu_icache_predecd_array0_clk_en,
  output logic [DATA_W-1:0]  ifu_icache_predecd_array0_din,
  input  logic [DATA_W-1:0]  icache_ifu_predecd_array0_dout
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [ENTRY_AW-1:0] CNT_LAST = '1;
  localparam int                  PAD_W    = INDEX_W - ENTRY_AW - 3;

  state_t              state;
  logic [ENTRY_AW-1:0] sweep_cnt;

  logic                sweep_act_p0;
  logic                refill_acc_p0;
  logic                fetch_acc_p0;
  logic                cen_b_p0;
  logic                wen_b_p0;
  logic [INDEX_W-1:0]  index_p0;
  logic [DATA_W-1:0]   din_p0;
  logic [INDEX_W-1:0]  sweep_index_p0;

  logic                vld_p1;
  logic [DATA_W-1:0]   rd_hold_p1;

  // invalidate sweep control; inv_req outside IDLE is dropped, not queued
  always_ff @(posedge forever_cpuclk or posedge cpurst) begin
    if (cpurst) begin
      state     <= IDLE;
      sweep_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (inv_req) begin
            state     <= SWEEP;
            sweep_cnt <= '0;
          end
        end
        SWEEP: begin
          sweep_cnt <= sweep_cnt + 1'b1;
          if (sweep_cnt == CNT_LAST) begin
            state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // stage p0: arbitration and array drive, sweep > refill > fetch
  assign sweep_act_p0   = (state == SWEEP);
  assign refill_acc_p0  = ~sweep_act_p0 & refill_wr_vld;
  assign fetch_acc_p0   = ~sweep_act_p0 & ~refill_wr_vld & fetch_rd_vld;
  assign sweep_index_p0 = {{PAD_W{1'b0}}, sweep_cnt, 3'b000};

  always_comb begin
    cen_b_p0 = 1'b1;
    wen_b_p0 = 1'b1;
    index_p0 = '0;
    din_p0   = '0;
    if (sweep_act_p0) begin
      cen_b_p0 = 1'b0;
      wen_b_p0 = 1'b0;
      index_p0 = sweep_index_p0;
    end else if (refill_acc_p0) begin
      cen_b_p0 = 1'b0;
      wen_b_p0 = 1'b0;
      index_p0 = refill_wr_index;
      din_p0   = refill_wr_data;
    end else if (fetch_acc_p0) begin
      cen_b_p0 = 1'b0;
      index_p0 = fetch_rd_index;
    end
  end

  assign refill_wr_rdy = ~sweep_act_p0;
  assign fetch_rd_rdy  = ~sweep_act_p0 & ~refill_wr_vld;

  assign ifu_icache_index                 = index_p0;
  assign ifu_icache_predecd_array0_cen_b  = cen_b_p0;
  assign ifu_icache_predecd_array0_wen_b  = wen_b_p0;
  assign ifu_icache_predecd_array0_clk_en = ~cen_b_p0;
  assign ifu_icache_predecd_array0_din    = din_p0;

  // stage p1: array dout arrives; hold it until the next read returns
  always_ff @(posedge forever_cpuclk or posedge cpurst) begin
    if (cpurst) begin
      vld_p1     <= 1'b0;
      rd_hold_p1 <= '0;
    end else begin
      vld_p1 <= fetch_acc_p0;
      if (vld_p1) begin
        rd_hold_p1 <= icache_ifu_predecd_array0_dout;
      end
    end
  end

  assign fetch_rd_data_vld = vld_p1;
  assign fetch_rd_data     = vld_p1 ? icache_ifu_predecd_array0_dout : rd_hold_p1;

  assign inv_busy = (state == SWEEP);
  assign inv_done = (state == DONE);

endmodule
